// File: rtl/adc_dly_pkg.sv
// adc_dly_pkg: shared state encoding and register-word field positions for the IDELAY loader
package adc_dly_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_CHECK,
    S_PULSE,
    S_WAIT,
    S_DONE
  } state_t;
  localparam int TAP_LSB  = 0;
  localparam int MASK_LSB = 8;
  localparam int ALL_BIT  = 30;
  localparam int TOG_BIT  = 31;
endpackage

// File: rtl/adc_dly_trig.sv
// adc_dly_trig: registers the software word, detects load toggles and holds one pending request
module adc_dly_trig
  import adc_dly_pkg::*;
(
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic [31:0] load_word,
  input  logic        idle,
  input  logic        capture,
  output logic        trig,
  output logic        pend,
  output logic [31:0] sel_word
);
  logic [31:0] cfg_q;
  logic [31:0] pend_word;
  logic        tog_prev;
  logic        primed;
  assign trig     = primed & (cfg_q[TOG_BIT] ^ tog_prev);
  assign sel_word = pend ? pend_word : cfg_q;
  // The unprimed cycle seeds tog_prev from the incoming word so a toggle bit already set at boot is not a request
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      cfg_q     <= '0;
      pend_word <= '0;
      tog_prev  <= 1'b0;
      primed    <= 1'b0;
      pend      <= 1'b0;
    end else begin
      cfg_q    <= load_word;
      primed   <= 1'b1;
      tog_prev <= primed ? cfg_q[TOG_BIT] : load_word[TOG_BIT];
      if (trig && !idle) begin
        pend      <= 1'b1;
        pend_word <= cfg_q;
      end else if (capture) begin
        pend <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/adc_in_dly_loader.sv
// adc_in_dly_loader: walks the lane mask and emits one IDELAY load strobe per selected lane
module adc_in_dly_loader
  import adc_dly_pkg::*;
#(
  parameter int NUM_LANES     = 16,
  parameter int TAP_W         = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                 user_clk,
  input  logic                 user_rst,
  input  logic [31:0]          load_word,
  output logic [NUM_LANES-1:0] dly_ld,
  output logic [TAP_W-1:0]     dly_val,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     load_count
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  state_t               state;
  logic [LW-1:0]        lane;
  logic [SW-1:0]        wcnt;
  logic [NUM_LANES-1:0] mask_r;
  logic                 trig;
  logic                 pend;
  logic [31:0]          sel_word;
  logic                 last_lane;
  logic                 unused_sel;
  assign busy       = state != S_IDLE;
  assign done       = state == S_DONE;
  assign last_lane  = lane == LW'(NUM_LANES - 1);
  assign unused_sel = ^sel_word;
  adc_dly_trig u_trig (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .load_word(load_word),
    .idle     (state == S_IDLE),
    .capture  (state == S_CAPTURE),
    .trig     (trig),
    .pend     (pend),
    .sel_word (sel_word)
  );
  // Sequencer: strobes are registered on the CHECK->PULSE transition so they coincide with PULSE
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state      <= S_IDLE;
      lane       <= '0;
      wcnt       <= '0;
      mask_r     <= '0;
      dly_ld     <= '0;
      dly_val    <= '0;
      load_count <= '0;
    end else begin
      dly_ld <= '0;
      case (state)
        S_IDLE: if (trig || pend) state <= S_CAPTURE;
        S_CAPTURE: begin
          dly_val <= sel_word[TAP_LSB +: TAP_W];
          mask_r  <= sel_word[ALL_BIT] ? '1 : sel_word[MASK_LSB +: NUM_LANES];
          lane    <= '0;
          state   <= S_CHECK;
        end
        S_CHECK: begin
          if (mask_r[lane]) begin
            dly_ld <= NUM_LANES'(1) << lane;
            state  <= S_PULSE;
          end else if (last_lane) begin
            state <= S_DONE;
          end else begin
            lane  <= lane + 1'b1;
            state <= S_CHECK;
          end
        end
        S_PULSE: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt != SW'(SETTLE_CYCLES - 1)) begin
            wcnt <= wcnt + 1'b1;
          end else if (last_lane) begin
            state <= S_DONE;
          end else begin
            lane  <= lane + 1'b1;
            state <= S_CHECK;
          end
        end
        S_DONE: begin
          load_count <= load_count + 1'b1;
          state      <= (pend || trig) ? S_CAPTURE : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_in_dly_loader.sv
// tb_adc_in_dly_loader: directed and randomized checks of the lane load sequencer against a timing model
module tb_adc_in_dly_loader;
  localparam int SETTLE = 4;
  typedef struct {
    int         cyc;
    int         lane;
    logic [4:0] val;
  } ev_t;
  logic        user_clk = 1'b0;
  logic        user_rst;
  logic [31:0] load_word;
  logic [15:0] dly_ld;
  logic [4:0]  dly_val;
  logic        busy;
  logic        done;
  logic [15:0] load_count;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          exp_count = 0;
  int          t0;
  int          dc;
  int          dc2;
  logic        tog = 1'b0;
  logic [31:0] w;
  logic [31:0] w2;
  logic [4:0]  prev_val = '0;
  logic [4:0]  val_hist [int];
  ev_t         pulse_q[$];
  ev_t         exp_q[$];
  int          busy_q[$];
  int          done_q[$];
  adc_in_dly_loader dut (
    .user_clk  (user_clk),
    .user_rst  (user_rst),
    .load_word (load_word),
    .dly_ld    (dly_ld),
    .dly_val   (dly_val),
    .busy      (busy),
    .done      (done),
    .load_count(load_count)
  );
  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) cyc = cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge user_clk) begin
    int ln;
    val_hist[cyc] = dly_val;
    if (busy) busy_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
    if (dly_ld != '0) begin
      ln = -1;
      for (int i = 0; i < 16; i++) if (dly_ld[i]) ln = i;
      chk($sformatf("onehot_c%0d", cyc), 32'($onehot(dly_ld)), 32'd1);
      chk($sformatf("val_stable_c%0d", cyc), 32'(dly_val), 32'(prev_val));
      pulse_q.push_back('{cyc, ln, dly_val});
    end
    prev_val = dly_val;
  end
  task automatic step();
    @(negedge user_clk);
    #2;
  endtask
  task automatic clear();
    pulse_q.delete();
    exp_q.delete();
    busy_q.delete();
    done_q.delete();
  endtask
  task automatic build(input logic [4:0] tap, input logic [15:0] mask, input logic all, output logic [31:0] wo);
    tog = ~tog;
    wo = {tog, all, 6'($urandom), mask, 3'($urandom), tap};
  endtask
  task automatic model(input logic [31:0] wi, input int cap, output int dco);
    logic [15:0] m;
    int t;
    m = wi[30] ? 16'hFFFF : wi[23:8];
    t = cap + 1;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        exp_q.push_back('{t + 1, i, wi[4:0]});
        t += 2 + SETTLE;
      end else begin
        t += 1;
      end
    end
    dco = t;
  endtask
  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_q.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("done_timeout", 32'(done_q.size() >= n), 32'd1);
  endtask
  task automatic cmp_pulses(input string tag);
    chk({tag, "_npulse"}, 32'(pulse_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < pulse_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_p%0d_cyc", tag, i), 32'(pulse_q[i].cyc), 32'(exp_q[i].cyc));
      chk($sformatf("%s_p%0d_lane", tag, i), 32'(pulse_q[i].lane), 32'(exp_q[i].lane));
      chk($sformatf("%s_p%0d_val", tag, i), 32'(pulse_q[i].val), 32'(exp_q[i].val));
    end
  endtask
  task automatic run_seq(input string tag, input logic [31:0] wi);
    clear();
    t0 = cyc;
    load_word = wi;
    model(wi, t0 + 2, dc);
    wait_done(1, 200);
    step();
    step();
    exp_count++;
    chk({tag, "_done_cyc"}, 32'(done_q.size() > 0 ? done_q[0] : -1), 32'(dc));
    chk({tag, "_done_n"}, 32'(done_q.size()), 32'd1);
    cmp_pulses(tag);
    chk({tag, "_val"}, 32'(val_hist[t0 + 3]), 32'(wi[4:0]));
    chk({tag, "_busy_len"}, 32'(busy_q.size()), 32'(dc - t0 - 1));
    chk({tag, "_busy_first"}, 32'(busy_q.size() > 0 ? busy_q[0] : -1), 32'(t0 + 2));
    chk({tag, "_count"}, 32'(load_count), 32'(exp_count & 16'hFFFF));
  endtask
  initial begin
    user_rst = 1'b1;
    load_word = '0;
    repeat (3) step();
    chk("rst_ld", 32'(dly_ld), 32'd0);
    chk("rst_val", 32'(dly_val), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(load_count), 32'd0);
    user_rst = 1'b0;
    repeat (3) step();
    build(5'h0B, 16'h0005, 1'b0, w);
    run_seq("basic", w);
    chk("basic_done_c29", 32'(done_q.size() > 0 ? done_q[0] - t0 : -1), 32'd29);
    for (int r = 0; r < 6; r++) begin
      build(5'($urandom), 16'($urandom), $urandom_range(0, 3) == 0, w);
      run_seq($sformatf("rand%0d", r), w);
      repeat ($urandom_range(0, 4)) step();
    end
    build(5'($urandom), 16'h0000, 1'b1, w);
    run_seq("all", w);
    for (int i = 1; i < pulse_q.size(); i++)
      chk($sformatf("all_gap%0d", i), 32'(pulse_q[i].cyc - pulse_q[i-1].cyc), 32'd6);
    build(5'($urandom), 16'h0000, 1'b0, w);
    run_seq("zero", w);
    chk("zero_done_c19", 32'(done_q.size() > 0 ? done_q[0] - t0 : -1), 32'd19);
    clear();
    build(5'($urandom), 16'($urandom) | 16'h0001, 1'b0, w);
    t0 = cyc;
    load_word = w;
    model(w, t0 + 2, dc);
    repeat (6) step();
    build(5'h03, 16'($urandom), 1'b0, w2);
    load_word = w2;
    repeat (4) step();
    build(5'h07, 16'($urandom), $urandom_range(0, 1) == 1, w2);
    load_word = w2;
    model(w2, dc + 1, dc2);
    wait_done(2, 400);
    repeat (40) step();
    exp_count += 2;
    chk("pend_done_n", 32'(done_q.size()), 32'd2);
    chk("pend_done1", 32'(done_q.size() > 0 ? done_q[0] : -1), 32'(dc));
    chk("pend_done2", 32'(done_q.size() > 1 ? done_q[1] : -1), 32'(dc2));
    cmp_pulses("pend");
    chk("pend_val2", 32'(val_hist[dc + 2]), 32'h07);
    chk("pend_busy_len", 32'(busy_q.size()), 32'(dc2 - t0 - 1));
    chk("pend_count", 32'(load_count), 32'(exp_count & 16'hFFFF));
    clear();
    build(5'h11, 16'h0008, 1'b0, w);
    load_word = w;
    repeat (9) step();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    user_rst = 1'b1;
    #1;
    chk("midrst_ld", 32'(dly_ld), 32'd0);
    chk("midrst_val", 32'(dly_val), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_count", 32'(load_count), 32'd0);
    exp_count = 0;
    step();
    step();
    user_rst = 1'b0;
    clear();
    repeat (30) step();
    chk("midrst_quiet_pulses", 32'(pulse_q.size()), 32'd0);
    chk("midrst_quiet_busy", 32'(busy_q.size()), 32'd0);
    build(5'($urandom), 16'($urandom), 1'b0, w);
    run_seq("after_rst", w);
    user_rst = 1'b1;
    tog = 1'b0;
    build(5'h1F, 16'hFFFF, 1'b0, w);
    load_word = w;
    step();
    step();
    user_rst = 1'b0;
    exp_count = 0;
    clear();
    repeat (40) step();
    chk("boot_tog_pulses", 32'(pulse_q.size()), 32'd0);
    chk("boot_tog_busy", 32'(busy_q.size()), 32'd0);
    chk("boot_tog_count", 32'(load_count), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
